// File: rtl/fpga_port_responder_if.sv
// Request/response bundle between an FPGA-side initiator and the port responder.
interface fpga_port_responder_if #(
    parameter int FPGA_ADDR_WIDTH = 23,
    parameter int FPGA_DATA_WIDTH = 32
);
    logic [FPGA_ADDR_WIDTH-1:0] fpga_addr;
    logic                       fpga_wr_en;
    logic                       fpga_rd_en;
    logic [FPGA_DATA_WIDTH-1:0] fpga_wr_data;
    logic                       fpga_req;
    logic                       fpga_ack;
    logic [FPGA_DATA_WIDTH-1:0] fpga_rd_data;
    logic                       fpga_err;

    modport master (
        output fpga_addr, fpga_wr_en, fpga_rd_en, fpga_wr_data, fpga_req,
        input  fpga_ack, fpga_rd_data, fpga_err
    );

    modport slave (
        input  fpga_addr, fpga_wr_en, fpga_rd_en, fpga_wr_data, fpga_req,
        output fpga_ack, fpga_rd_data, fpga_err
    );
endinterface

// File: rtl/fpga_port_responder.sv
// Memory-port responder: fixed-latency read/write acks into a small register
// store, with periodic refresh windows that block the port.
module fpga_port_responder #(
    parameter int FPGA_ADDR_WIDTH  = 23,
    parameter int FPGA_DATA_WIDTH  = 32,
    parameter int MEM_ADDR_WIDTH   = 6,
    parameter int WR_LATENCY       = 4,
    parameter int RD_LATENCY       = 6,
    parameter int REFRESH_INTERVAL = 1024,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic                  fpga_clk,
    input  logic                  fpga_reset,
    fpga_port_responder_if.slave  port,
    output logic                  busy,
    output logic                  refresh_active
);
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam int REF_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int RCY_W = $clog2(REFRESH_CYCLES + 1);
    localparam int LAT_W = 4;

    if (WR_LATENCY < 2 || WR_LATENCY > 15 || RD_LATENCY < 2 || RD_LATENCY > 15) begin : g_bad_latency
        $error("fpga_port_responder: latencies must lie in 2..15");
    end

    typedef enum logic [1:0] {IDLE, REFRESH, ACCESS, ACK} state_t;

    state_t                      state, state_nxt;
    logic [REF_W-1:0]            ref_cnt;
    logic                        ref_pend;
    logic [RCY_W-1:0]            rcy_cnt;
    logic [LAT_W-1:0]            lat_cnt;
    logic [MEM_ADDR_WIDTH-1:0]   idx_q;
    logic [FPGA_DATA_WIDTH-1:0]  data_q;
    logic                        op_wr, op_rd, op_err;
    logic [FPGA_DATA_WIDTH-1:0]  rd_data_q;
    logic [FPGA_DATA_WIDTH-1:0]  mem [0:DEPTH-1];

    logic accept, take_refresh, ack_entry, ref_expire;
    logic unused_addr_hi;

    assign unused_addr_hi = ^port.fpga_addr[FPGA_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

    assign take_refresh = (state == IDLE) && ref_pend;
    assign ack_entry    = (state == ACCESS) && (lat_cnt == LAT_W'(1));
    assign ref_expire   = (ref_cnt == REF_W'(REFRESH_INTERVAL - 1));

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    // Refresh has priority over a request arriving in the same IDLE cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pend) begin
                    state_nxt = REFRESH;
                end else if (port.fpga_req && (port.fpga_wr_en || port.fpga_rd_en)) begin
                    state_nxt = ACCESS;
                    accept    = 1'b1;
                end
            end
            REFRESH: if (rcy_cnt == '0) state_nxt = IDLE;
            ACCESS:  if (lat_cnt == LAT_W'(1)) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
            rcy_cnt  <= '0;
        end else begin
            if (ref_expire) begin
                ref_cnt  <= '0;
                ref_pend <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
                if (take_refresh) ref_pend <= 1'b0;
            end
            if (take_refresh)
                rcy_cnt <= RCY_W'(REFRESH_CYCLES - 1);
            else if (state == REFRESH && rcy_cnt != '0)
                rcy_cnt <= rcy_cnt - RCY_W'(1);
        end
    end

    // Counter holds latency-1 so that ack is visible on the Nth edge after acceptance.
    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            lat_cnt <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            op_wr   <= 1'b0;
            op_rd   <= 1'b0;
            op_err  <= 1'b0;
        end else if (accept) begin
            lat_cnt <= port.fpga_wr_en ? LAT_W'(WR_LATENCY - 1) : LAT_W'(RD_LATENCY - 1);
            idx_q   <= port.fpga_addr[MEM_ADDR_WIDTH-1:0];
            data_q  <= port.fpga_wr_data;
            op_wr   <= port.fpga_wr_en & ~port.fpga_rd_en;
            op_rd   <= port.fpga_rd_en & ~port.fpga_wr_en;
            op_err  <= port.fpga_wr_en & port.fpga_rd_en;
        end else if (state == ACCESS) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
        end
    end

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (ack_entry && op_wr) begin
            mem[idx_q] <= data_q;
        end
    end

    always_ff @(posedge fpga_clk or posedge fpga_reset) begin
        if (fpga_reset)              rd_data_q <= '0;
        else if (ack_entry && op_rd) rd_data_q <= mem[idx_q];
    end

    assign port.fpga_ack     = (state == ACK);
    assign port.fpga_err     = (state == ACK) && op_err;
    assign port.fpga_rd_data = rd_data_q;
    assign busy              = (state != IDLE);
    assign refresh_active    = (state == REFRESH);
endmodule
